// File: rtl/uni_shift_seq.sv
// uni_shift_seq: command sequencer for a WIDTH-bit universal shift register.
//
// Accepts hold / shift-right / shift-left / load commands, queues them in a
// small FIFO, and expands each one into a cycle-accurate stream of register
// controls (sel, serial-in bits, parallel_in). Every control output is a
// flop, so nothing on cmd_* reaches the register combinationally.
//
// Optional feature: define USEQ_FLUSH_EN to add the synchronous 'flush' input.
// It empties the FIFO and aborts the running command without a done pulse.
//
// Handshake: a command is transferred on a rising edge where
// cmd_valid && cmd_ready. cmd_ready is !full and does not depend on cmd_valid.
// The source holds cmd_op/cmd_data/cmd_cnt stable while cmd_valid && !cmd_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   flush        (USEQ_FLUSH_EN only) clear FIFO and abort current command
//   cmd_valid    command offered
//   cmd_ready    FIFO can accept (= !full)
//   cmd_op       00 hold, 01 shift right, 10 shift left, 11 load
//   cmd_data     load value, or serial pattern sent LSB first
//   cmd_cnt      repeat count; command lasts cmd_cnt+1 cycles (not for load)
//   sel          register mode select
//   shift_r_in   serial input for shift right
//   shift_l_in   serial input for shift left
//   parallel_in  register load value
//   busy         a command is driven this cycle
//   done         pulse on the final drive cycle of each command
//   fsm_state    debug view of the FSM (0 IDLE, 1 RUN)
module uni_shift_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef USEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [1:0]       sel,
  output logic             shift_r_in,
  output logic             shift_l_in,
  output logic [WIDTH-1:0] parallel_in,
  output logic             busy,
  output logic             done,
  output logic             fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + WIDTH + CNT_W;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  // Command FIFO, entry = {op, data, cnt}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Current command
  logic             state;
  logic [1:0]       cur_op;
  logic [WIDTH-1:0] cur_data;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] k;

  logic flush_now;
`ifdef USEQ_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  logic full, empty, push, pop, last;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_data;
  logic [CNT_W-1:0] head_cnt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign head      = mem[rd_ptr];
  assign head_op   = head[EW-1 -: 2];
  assign head_data = head[CNT_W +: WIDTH];
  assign head_cnt  = head[CNT_W-1:0];
  assign fsm_state = state;

  // A push coinciding with flush is dropped.
  assign push = cmd_valid && !full && !flush_now;
  // Load always finishes in its first cycle regardless of cnt.
  assign last = (state == RUN) && ((cur_op == 2'b11) || (k == cur_cnt));
  // Popping on the last cycle chains commands with no idle bubble.
  assign pop  = !empty && !flush_now && ((state == IDLE) || last);

  // Next-cycle command context
  logic             nxt_state;
  logic [1:0]       nxt_op;
  logic [WIDTH-1:0] nxt_data;
  logic [CNT_W-1:0] nxt_cnt, nxt_k;

  always_comb begin
    nxt_state = state;
    nxt_op    = cur_op;
    nxt_data  = cur_data;
    nxt_cnt   = cur_cnt;
    nxt_k     = k;
    if (flush_now) begin
      nxt_state = IDLE;
    end else if (pop) begin
      nxt_state = RUN;
      nxt_op    = head_op;
      nxt_data  = head_data;
      nxt_cnt   = head_cnt;
      nxt_k     = '0;
    end else if (last) begin
      nxt_state = IDLE;
    end else if (state == RUN) begin
      nxt_k = k + CNT_W'(1);
    end
  end

  // Outputs for the next cycle, registered below.
  logic [1:0]       n_sel;
  logic             n_sr, n_sl, n_busy, n_done;
  logic [WIDTH-1:0] n_pin;
  logic [IW-1:0]    bit_idx;

  always_comb begin
    n_sel   = 2'b00;
    n_sr    = 1'b0;
    n_sl    = 1'b0;
    n_pin   = '0;
    n_busy  = 1'b0;
    n_done  = 1'b0;
    // Serial pattern wraps when the count exceeds the data width.
    bit_idx = IW'(int'(nxt_k) % WIDTH);
    if (nxt_state == RUN) begin
      n_sel  = nxt_op;
      n_busy = 1'b1;
      n_done = (nxt_op == 2'b11) || (nxt_k == nxt_cnt);
      case (nxt_op)
        2'b01:   n_sr  = nxt_data[bit_idx];
        2'b10:   n_sl  = nxt_data[bit_idx];
        2'b11:   n_pin = nxt_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data, cmd_cnt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cur_op      <= 2'b00;
      cur_data    <= '0;
      cur_cnt     <= '0;
      k           <= '0;
      sel         <= 2'b00;
      shift_r_in  <= 1'b0;
      shift_l_in  <= 1'b0;
      parallel_in <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cur_op      <= nxt_op;
      cur_data    <= nxt_data;
      cur_cnt     <= nxt_cnt;
      k           <= nxt_k;
      sel         <= n_sel;
      shift_r_in  <= n_sr;
      shift_l_in  <= n_sl;
      parallel_in <= n_pin;
      busy        <= n_busy;
      done        <= n_done;
    end
  end

endmodule

// File: tb/tb_uni_shift_seq.sv
// Testbench for uni_shift_seq (default parameters WIDTH=4, CNT_W=2, DEPTH=4).
// A reference model expands each accepted command into its per-cycle output
// stream and is compared against the DUT on every clock.
module tb_uni_shift_seq;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [1:0]       sel;
  logic             shift_r_in, shift_l_in;
  logic [WIDTH-1:0] parallel_in;
  logic             busy, done, fsm_state;
`ifdef USEQ_FLUSH_EN
  logic             flush = 1'b0;
`endif

  uni_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef USEQ_FLUSH_EN
    .flush       (flush),
`endif
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cmd_cnt     (cmd_cnt),
    .sel         (sel),
    .shift_r_in  (shift_r_in),
    .shift_l_in  (shift_l_in),
    .parallel_in (parallel_in),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  typedef struct packed {
    logic [1:0]       sel;
    logic             sr;
    logic             sl;
    logic [WIDTH-1:0] pin;
    logic             busy;
    logic             done;
  } out_t;

  cmd_t pend_q[$];          // accepted, not yet started
  out_t exp_q[$];           // remaining cycles of the running command
  out_t exp_o = '0;
  logic exp_ready = 1'b1;
  logic last_acc = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, req);
  endtask

  // Command -> list of per-cycle outputs, straight from the command rules.
  function automatic void expand(input cmd_t c);
    out_t o;
    int n;
    if (c.op == 2'b11) begin
      o = '0; o.sel = 2'b11; o.pin = c.data; o.busy = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
    end else begin
      n = int'(c.cnt) + 1;
      for (int i = 0; i < n; i++) begin
        o = '0;
        o.sel  = c.op;
        o.busy = 1'b1;
        o.sr   = (c.op == 2'b01) ? c.data[i % WIDTH] : 1'b0;
        o.sl   = (c.op == 2'b10) ? c.data[i % WIDTH] : 1'b0;
        o.done = (i == n - 1);
        exp_q.push_back(o);
      end
    end
  endfunction

  // One clock: advance model at the edge, compare DUT 1 ns later.
  task automatic tick();
    cmd_t c;
    logic acc, do_flush;
    logic [10:0] act;
    @(posedge clk);
    acc = 1'b0;
    do_flush = 1'b0;
`ifdef USEQ_FLUSH_EN
    do_flush = flush;
`endif
    c.op = cmd_op; c.data = cmd_data; c.cnt = cmd_cnt;
    if (!rst || do_flush) begin
      pend_q.delete();
      exp_q.delete();
      exp_o = '0;
    end else begin
      acc = cmd_valid && (pend_q.size() < DEPTH);
      if (exp_q.size() == 0 && pend_q.size() != 0) expand(pend_q.pop_front());
      if (exp_q.size() != 0) exp_o = exp_q.pop_front();
      else exp_o = '0;
      if (acc) pend_q.push_back(c);
    end
    exp_ready = (pend_q.size() < DEPTH);
    last_acc = acc;
    #1;
    act = {cmd_ready, sel, shift_r_in, shift_l_in, parallel_in, busy, done};
    check("cycle", 32'(act), 32'({exp_ready, exp_o}));
    if (done) done_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] data,
                      input logic [CNT_W-1:0] cnt, output int waited);
    cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_valid = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!last_acc && waited < 50);
    cmd_valid = 1'b0;
    check("push_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && g < 100) begin
      tick();
      g++;
    end
    tick();
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       e_sel;
    logic             e_sr;
    logic             e_sl;
    logic [WIDTH-1:0] e_pin;
    logic             e_done;
    int               e_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, len, guard, d0, n;
    logic [WIDTH-1:0] regq, seq;
    logic busy_all;

    vecs[0] = '{2'b11, 4'b1001, 2'd2, 2'b11, 1'b0, 1'b0, 4'b1001, 1'b1, 1};
    vecs[1] = '{2'b01, 4'b0001, 2'd1, 2'b01, 1'b1, 1'b0, 4'b0000, 1'b0, 2};
    vecs[2] = '{2'b10, 4'b0101, 2'd3, 2'b10, 1'b0, 1'b1, 4'b0000, 1'b0, 4};
    vecs[3] = '{2'b00, 4'b1111, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 1};
    vecs[4] = '{2'b01, 4'b1110, 2'd3, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 4};
    vecs[5] = '{2'b10, 4'b0010, 2'd0, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b1, 1};

    // Reset held with a command offered: nothing stored, outputs idle.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'hF;
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", 32'({sel, shift_r_in, shift_l_in, parallel_in, busy, done}), 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single commands from idle.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].op, vecs[i].data, vecs[i].cnt, w);
      tick();
      check("vec_sel",  32'(sel),         32'(vecs[i].e_sel));
      check("vec_sr",   32'(shift_r_in),  32'(vecs[i].e_sr));
      check("vec_sl",   32'(shift_l_in),  32'(vecs[i].e_sl));
      check("vec_pin",  32'(parallel_in), 32'(vecs[i].e_pin));
      check("vec_done", 32'(done),        32'(vecs[i].e_done));
      len = 0; guard = 0;
      while (busy && guard < 40) begin
        len++; guard++;
        tick();
      end
      check("vec_len", 32'(len), 32'(vecs[i].e_len));
    end

    // Load 1001, then shift right pattern 0001 for 2 cycles.
    d0 = done_seen;
    push(2'b11, 4'b1001, 2'd0, w);
    push(2'b01, 4'b0001, 2'd1, w);
    check("ls_load_sel", 32'(sel), 32'(2'b11));
    regq = parallel_in;
    check("ls_reg0", 32'(regq), 32'(4'b1001));
    tick();
    regq = {shift_r_in, regq[WIDTH-1:1]};
    check("ls_reg1", 32'(regq), 32'(4'b1100));
    tick();
    regq = {shift_r_in, regq[WIDTH-1:1]};
    check("ls_reg2", 32'(regq), 32'(4'b0110));
    tick();
    check("ls_done_cnt", 32'(done_seen - d0), 32'd2);

    // Shift left with serial pattern 0101 over 4 cycles.
    push(2'b10, 4'b0101, 2'd3, w);
    seq = '0; busy_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = shift_l_in;
      busy_all = busy_all & busy;
    end
    check("shl_seq", 32'(seq), 32'(4'b0101));
    check("shl_busy", 32'(busy_all), 32'd1);
    tick();

    // Three back-to-back commands: 4 busy cycles with no gap.
    d0 = done_seen;
    push(2'b01, 4'b0001, 2'd0, w);
    push(2'b10, 4'b0011, 2'd1, w);
    push(2'b00, 4'b0000, 2'd0, w);
    n = 2; guard = 0;
    while (guard < 20) begin
      guard++;
      tick();
      if (!busy) break;
      n++;
    end
    check("b2b_busy_len", 32'(n), 32'd4);
    check("b2b_done_cnt", 32'(done_seen - d0), 32'd3);

    // Fill the FIFO behind a 4-cycle hold.
    d0 = done_seen;
    push(2'b00, 4'b0000, 2'd3, w);
    push(2'b11, 4'd1, 2'd0, w);
    push(2'b11, 4'd2, 2'd0, w);
    push(2'b11, 4'd3, 2'd0, w);
    push(2'b11, 4'd4, 2'd0, w);
    check("full_ready", 32'(cmd_ready), 32'd0);
    push(2'b11, 4'd5, 2'd0, w);
    check("full_wait", 32'(w), 32'd2);
    wait_idle();
    check("full_done_cnt", 32'(done_seen - d0), 32'd6);

`ifdef USEQ_FLUSH_EN
    // Flush mid-shift with two loads queued.
    d0 = done_seen;
    push(2'b01, 4'b1010, 2'd3, w);
    push(2'b11, 4'd7, 2'd0, w);
    push(2'b11, 4'd8, 2'd0, w);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_sel", 32'(sel), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    check("flush_no_done", 32'(done_seen - d0), 32'd0);
`endif

    // Asynchronous reset in the middle of a command with one queued.
    push(2'b10, 4'b1111, 2'd3, w);
    push(2'b11, 4'b0110, 2'd0, w);
    #3 rst = 1'b0;
    #1;
    check("arst_outputs", 32'({sel, shift_r_in, shift_l_in, parallel_in, busy, done}), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("arst_dropped", 32'(busy), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
        cmd_cnt   = 2'($urandom_range(0, 3));
      end
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
